dmem_lsu: RTL and testbench

Parametrised load/store unit between the core datapath and the single-port data memory. Accepts one load or store per handshake, generates byte enables, shifts store data into byte lanes and sign/zero-extends load data, and returns a tagged response for writeback. Replaces direct datapath drive of the memory `wr`/`rd`/`addr` signals. Optionally splits word-crossing accesses into two memory beats.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_align.sv | 47 ++++
 rtl/dmem_lsu.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM state encoding and the access-size decoder.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        LDW  = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic       legal;
        logic       sgn;
        logic [3:0] bytes;
    } size_info_t;

    // Unsigned codes are load-only; D and WU exist only on a 64-bit datapath.
    function automatic size_info_t decode_size(input logic [2:0] f3, input logic we,
                                               input int data_w);
        size_info_t r;
        r.legal = 1'b0;
        r.sgn   = 1'b1;
        r.bytes = 4'd1;
        case (f3)
            F3_B:  begin r.legal = 1'b1;                r.bytes = 4'd1; end
            F3_H:  begin r.legal = 1'b1;                r.bytes = 4'd2; end
            F3_W:  begin r.legal = 1'b1;                r.bytes = 4'd4; end
            F3_D:  begin r.legal = (data_w == 64);      r.bytes = 4'd8; end
            F3_BU: begin r.legal = !we; r.sgn = 1'b0;   r.bytes = 4'd1; end
            F3_HU: begin r.legal = !we; r.sgn = 1'b0;   r.bytes = 4'd2; end
            F3_WU: begin r.legal = !we && (data_w == 64); r.sgn = 1'b0; r.bytes = 4'd4; end
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-enable/data shift over a two-word
// window, and load assembly from two words with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            st_wdata_i,
    input  logic [$clog2(DATA_W/8)-1:0]  st_off_i,
    input  logic [3:0]                   st_size_i,
    output logic [2*(DATA_W/8)-1:0]      be2_o,
    output logic [2*DATA_W-1:0]          wd2_o,
    input  logic [DATA_W-1:0]            ld_lo_i,
    input  logic [DATA_W-1:0]            ld_hi_i,
    input  logic [$clog2(DATA_W/8)-1:0]  ld_off_i,
    input  logic [3:0]                   ld_size_i,
    input  logic                         ld_sgn_i,
    output logic [DATA_W-1:0]            ld_data_o
);
    localparam int NB = DATA_W / 8;

    logic [2*NB-1:0]     mask;
    logic [2*DATA_W-1:0] comb;
    logic [6:0]          msb_idx;
    logic                fill;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            mask[i] = (4'(i) < st_size_i);
        end
        be2_o = mask << st_off_i;
        wd2_o = {{DATA_W{1'b0}}, st_wdata_i} << {st_off_i, 3'b000};
    end

    // The two-word window shifted down by the offset puts the access at byte 0.
    always_comb begin
        comb    = {ld_hi_i, ld_lo_i} >> {ld_off_i, 3'b000};
        msb_idx = {ld_size_i, 3'b000} - 7'd1;
        fill    = ld_sgn_i && (ld_size_i != 4'd0) && comb[msb_idx];
        ld_data_o = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            ld_data_o[8*i +: 8] = (4'(i) < ld_size_i) ? comb[8*i +: 8] : {8{fill}};
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit FSM between the datapath and single-port data memory.
// Define DMEM_LSU_SPLIT_EN to split word-crossing accesses into two beats.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_we,
    input  logic [2:0]                          req_funct3,
    input  logic [ADDR_W-1:0]                   req_addr,
    input  logic [DATA_W-1:0]                   req_wdata,
    input  logic [4:0]                          req_rd,
    output logic                                resp_valid,
    output logic                                resp_err,
    output logic [DATA_W-1:0]                   resp_rdata,
    output logic [4:0]                          resp_rd,
    output logic                                wr,
    output logic                                rd,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]  addr,
    output logic [DATA_W-1:0]                   wr_data,
    output logic [DATA_W/8-1:0]                 be,
    input  logic [DATA_W-1:0]                   mem_rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int WA_W  = ADDR_W - OFF_W;

    lsu_state_t          state_q;
    logic                ready_q, wr_q, rd_q, resp_valid_q, resp_err_q;
    logic [WA_W-1:0]     addr_q;
    logic [NB-1:0]       be_q;
    logic [DATA_W-1:0]   wdat_q, resp_rdata_q;
    logic [4:0]          resp_rd_q, tag_q;
    logic                we_q, sgn_q;
    logic [3:0]          size_q;
    logic [OFF_W-1:0]    off_q;

    size_info_t          dec;
    logic [OFF_W-1:0]    req_off;
    logic [4:0]          span;
    logic                req_cross, req_fault;
    logic [2*NB-1:0]     be2;
    logic [2*DATA_W-1:0] wd2;
    logic [DATA_W-1:0]   ld_lo, ld_hi, ld_data;

`ifdef DMEM_LSU_SPLIT_EN
    logic                cross_q;
    logic [NB-1:0]       be_hi_q;
    logic [DATA_W-1:0]   wd_hi_q, lo_q;
`else
    logic                unused_hi;
    assign unused_hi = ^{be2[2*NB-1:NB], wd2[2*DATA_W-1:DATA_W]};
`endif

    always_comb begin
        dec       = decode_size(req_funct3, req_we, DATA_W);
        req_off   = req_addr[OFF_W-1:0];
        span      = 5'(req_off) + 5'(dec.bytes);
        req_cross = (span > 5'(NB));
`ifdef DMEM_LSU_SPLIT_EN
        req_fault = !dec.legal;
        ld_lo     = cross_q ? lo_q : mem_rdata;
        ld_hi     = mem_rdata;
`else
        req_fault = !dec.legal || req_cross;
        ld_lo     = mem_rdata;
        ld_hi     = '0;
`endif
    end

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .st_wdata_i (req_wdata),
        .st_off_i   (req_off),
        .st_size_i  (dec.bytes),
        .be2_o      (be2),
        .wd2_o      (wd2),
        .ld_lo_i    (ld_lo),
        .ld_hi_i    (ld_hi),
        .ld_off_i   (off_q),
        .ld_size_i  (size_q),
        .ld_sgn_i   (sgn_q),
        .ld_data_o  (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdat_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            tag_q        <= '0;
            we_q         <= 1'b0;
            sgn_q        <= 1'b0;
            size_q       <= '0;
            off_q        <= '0;
`ifdef DMEM_LSU_SPLIT_EN
            cross_q      <= 1'b0;
            be_hi_q      <= '0;
            wd_hi_q      <= '0;
            lo_q         <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        if (req_fault) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rd_q    <= req_we ? 5'd0 : req_rd;
                        end else begin
                            state_q <= B1;
                            ready_q <= 1'b0;
                            wr_q    <= req_we;
                            rd_q    <= !req_we;
                            addr_q  <= req_addr[ADDR_W-1:OFF_W];
                            be_q    <= be2[NB-1:0];
                            wdat_q  <= req_we ? wd2[DATA_W-1:0] : '0;
                            we_q    <= req_we;
                            sgn_q   <= dec.sgn;
                            size_q  <= dec.bytes;
                            off_q   <= req_off;
                            tag_q   <= req_rd;
`ifdef DMEM_LSU_SPLIT_EN
                            cross_q <= req_cross;
                            be_hi_q <= be2[2*NB-1:NB];
                            wd_hi_q <= req_we ? wd2[2*DATA_W-1:DATA_W] : '0;
`endif
                        end
                    end
                end
                B1: begin
`ifdef DMEM_LSU_SPLIT_EN
                    if (cross_q) begin
                        state_q <= B2;
                        addr_q  <= addr_q + WA_W'(1);
                        be_q    <= be_hi_q;
                        wdat_q  <= wd_hi_q;
                    end else
`endif
                    begin
                        wr_q   <= 1'b0;
                        rd_q   <= 1'b0;
                        addr_q <= '0;
                        be_q   <= '0;
                        wdat_q <= '0;
                        if (we_q) begin
                            state_q      <= IDLE;
                            ready_q      <= 1'b1;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= LDW;
                        end
                    end
                end
`ifdef DMEM_LSU_SPLIT_EN
                B2: begin
                    lo_q   <= mem_rdata;
                    wr_q   <= 1'b0;
                    rd_q   <= 1'b0;
                    addr_q <= '0;
                    be_q   <= '0;
                    wdat_q <= '0;
                    if (we_q) begin
                        state_q      <= IDLE;
                        ready_q      <= 1'b1;
                        resp_valid_q <= 1'b1;
                    end else begin
                        state_q <= LDW;
                    end
                end
`endif
                LDW: begin
                    state_q      <= IDLE;
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= ld_data;
                    resp_rd_q    <= tag_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = resp_rd_q;
    assign wr         = wr_q;
    assign rd         = rd_q;
    assign addr       = addr_q;
    assign wr_data    = wdat_q;
    assign be         = be_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu (DATA_W=32, ADDR_W=9) with a byte-enabled
// memory model; expectations follow DMEM_LSU_SPLIT_EN when it is defined.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [8:0]  req_addr = 9'b0;
    logic [31:0] req_wdata = 32'b0;
    logic [4:0]  req_rd = 5'b0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        wr, rd;
    logic [6:0]  addr;
    logic [31:0] wr_data;
    logic [3:0]  be;
    logic [31:0] mem_rdata = 32'b0;

    logic [31:0] mem [128];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.DATA_W(32), .ADDR_W(9)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .resp_rd(resp_rd), .wr(wr), .rd(rd),
        .addr(addr), .wr_data(wr_data), .be(be), .mem_rdata(mem_rdata)
    );

    initial for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
        if (rd) mem_rdata <= mem[addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of T+1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, input logic [4:0] tag);
        chk("ready_at_issue", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = tag;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'b0;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_wr", {31'b0, wr}, 32'd0);
        settle(2);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_resp", {31'b0, resp_valid}, 32'd0);

        // SW 0xDEADBEEF @0x004
        issue(1'b1, 3'b010, 9'h004, 32'hDEADBEEF, 5'd3);
        chk("sw_wr", {31'b0, wr}, 32'd1);
        chk("sw_addr", {25'b0, addr}, 32'd1);
        chk("sw_be", {28'b0, be}, 32'hF);
        chk("sw_wdata", wr_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_resp", {30'b0, resp_valid, resp_err}, 32'b10);
        chk("sw_resp_rd", {27'b0, resp_rd}, 32'd0);
        chk("sw_wr_off", {31'b0, wr}, 32'd0);

        // LW @0x004 back-to-back
        issue(1'b0, 3'b010, 9'h004, 32'h0, 5'd5);
        chk("lw_rd", {31'b0, rd}, 32'd1);
        chk("lw_be", {28'b0, be}, 32'hF);
        @(negedge clk);
        chk("lw_t2_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("lw_resp", {30'b0, resp_valid, resp_err}, 32'b10);
        chk("lw_data", resp_rdata, 32'hDEADBEEF);
        chk("lw_tag", {27'b0, resp_rd}, 32'd5);

        // SB 0x80 @0x013, then LB / LBU
        issue(1'b1, 3'b000, 9'h013, 32'h00000080, 5'd0);
        chk("sb_be", {28'b0, be}, 32'b1000);
        chk("sb_addr", {25'b0, addr}, 32'd4);
        chk("sb_wdata", wr_data, 32'h80000000);
        @(negedge clk);
        chk("sb_resp", {31'b0, resp_valid}, 32'd1);
        issue(1'b0, 3'b000, 9'h013, 32'h0, 5'd7);
        settle(2);
        chk("lb_data", resp_rdata, 32'hFFFFFF80);
        chk("lb_tag", {27'b0, resp_rd}, 32'd7);
        issue(1'b0, 3'b100, 9'h013, 32'h0, 5'd8);
        settle(2);
        chk("lbu_data", resp_rdata, 32'h00000080);

        // illegal codes: SBU store, D load on 32-bit
        issue(1'b1, 3'b100, 9'h020, 32'h1234, 5'd4);
        chk("sbu_err", {30'b0, resp_valid, resp_err}, 32'b11);
        chk("sbu_no_wr", {31'b0, wr}, 32'd0);
        chk("sbu_rd_tag", {27'b0, resp_rd}, 32'd0);
        issue(1'b0, 3'b011, 9'h020, 32'h0, 5'd6);
        chk("ld_err", {30'b0, resp_valid, resp_err}, 32'b11);
        chk("ld_err_tag", {27'b0, resp_rd}, 32'd6);
        chk("ld_err_data", resp_rdata, 32'd0);

        // word 2 = 0x12345678, then crossing LW @0x006
        issue(1'b1, 3'b010, 9'h008, 32'h12345678, 5'd0);
        @(negedge clk);
        issue(1'b0, 3'b010, 9'h006, 32'h0, 5'd10);
`ifdef DMEM_LSU_SPLIT_EN
        chk("xlw_b1", {20'b0, rd, 4'b0, addr}, {20'b0, 1'b1, 4'b0, 7'd1});
        chk("xlw_b1_be", {28'b0, be}, 32'b1100);
        @(negedge clk);
        chk("xlw_b2", {20'b0, rd, 4'b0, addr}, {20'b0, 1'b1, 4'b0, 7'd2});
        chk("xlw_b2_be", {28'b0, be}, 32'b0011);
        @(negedge clk);
        chk("xlw_t3_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("xlw_resp", {30'b0, resp_valid, resp_err}, 32'b10);
        chk("xlw_data", resp_rdata, 32'h5678DEAD);
`else
        chk("xlw_err", {30'b0, resp_valid, resp_err}, 32'b11);
        chk("xlw_no_rd", {31'b0, rd}, 32'd0);
        @(negedge clk);
        chk("xlw_no_rd2", {31'b0, rd}, 32'd0);
`endif

        // crossing SH @0x1FF wraps to word 0
        issue(1'b1, 3'b001, 9'h1FF, 32'h0000CAFE, 5'd0);
`ifdef DMEM_LSU_SPLIT_EN
        chk("xsh_b1", {21'b0, be, addr}, {21'b0, 4'b1000, 7'd127});
        chk("xsh_b1_wd", wr_data, 32'hFE000000);
        @(negedge clk);
        chk("xsh_b2", {21'b0, be, addr}, {21'b0, 4'b0001, 7'd0});
        chk("xsh_b2_wd", wr_data, 32'h000000CA);
        @(negedge clk);
        chk("xsh_resp", {30'b0, resp_valid, resp_err}, 32'b10);
`else
        chk("xsh_err", {30'b0, resp_valid, resp_err}, 32'b11);
        chk("xsh_no_wr", {31'b0, wr}, 32'd0);
`endif
        issue(1'b0, 3'b100, 9'h000, 32'h0, 5'd1);
        settle(2);
`ifdef DMEM_LSU_SPLIT_EN
        chk("w0_byte", resp_rdata, 32'h000000CA);
`else
        chk("w0_byte", resp_rdata, 32'h00000000);
`endif
        issue(1'b0, 3'b100, 9'h1FF, 32'h0, 5'd2);
        settle(2);
`ifdef DMEM_LSU_SPLIT_EN
        chk("w127_byte", resp_rdata, 32'h000000FE);
`else
        chk("w127_byte", resp_rdata, 32'h00000000);
`endif

        // reset during an in-flight load (B2 when split, B1 otherwise)
`ifdef DMEM_LSU_SPLIT_EN
        issue(1'b0, 3'b010, 9'h006, 32'h0, 5'd11);
        @(negedge clk);
`else
        issue(1'b0, 3'b010, 9'h004, 32'h0, 5'd11);
`endif
        chk("inflight_rd", {31'b0, rd}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_rd", {31'b0, rd}, 32'd0);
        chk("arst_be_addr", {21'b0, be, addr}, 32'd0);
        chk("arst_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("arst_resp", {31'b0, resp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'b0, req_ready}, 32'd1);
        chk("rel_no_resp", {31'b0, resp_valid}, 32'd0);
        issue(1'b0, 3'b010, 9'h004, 32'h0, 5'd9);
        settle(2);
        chk("post_lw_resp", {30'b0, resp_valid, resp_err}, 32'b10);
        chk("post_lw_data", resp_rdata, 32'hDEADBEEF);
        chk("post_lw_tag", {27'b0, resp_rd}, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
